sram_wrap_l1_64x1024: RTL and testbench
=======================================

Name: sram_wrap_l1_64x1024

Overview:
Behavioural wrapper around a 1024-word x 64-bit single-port SRAM that serves as the L1 cache data store. Writes complete in one cycle with per-byte write masks. Reads return data after a fixed multi-cycle latency, flagged by a data_ready handshake. The core/cache controller drives the block through active-low chip-select and write-enable strobes, following standard SRAM-macro conventions.

Parameters:
NUM_WMASKS, 8, number of byte write-enable bits (one per 8 data bits)
DATA_WIDTH, 65, encoded width constant; data ports are DATA_WIDTH-1 = 64 bits
ADDR_WIDTH, 11, encoded width constant; address port is ADDR_WIDTH = 11 bits; depth 1024 words
READ_LATENCY, 6, clock edges from read acceptance to data_ready assertion

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  reset, synchronous, active-high (name kept per codebase convention)
csb  input  1  chip select, active low
we  input  1  write enable, active low (0 = write, 1 = read)
addr  input  11  word address; addr[9:0] indexes the array, addr[10] ignored (aliases)
data_in  input  64  write data
wmask  input  8  byte enables; wmask[i] enables data bits [8i+7:8i]
data_out  output  64  read data
data_ready  output  1  read data valid

Behaviour:
- All state updates occur on the rising edge of clk. Reset has priority over all other actions.
- Reset (rst_n=1 at an edge): state <= IDLE; latency counter <= 0; data_out <= 0; data_ready <= 0. Array contents are not cleared.
- FSM states: IDLE, READ_WAIT, READ_DONE.
- IDLE, csb=1: no operation; outputs hold.
- IDLE, csb=0 and we=0 (write): for each i with wmask[i]=1, mem[addr[9:0]] byte i <= data_in byte i; other bytes are unchanged. Stay in IDLE. data_ready stays 0.
  - Holding csb=0 for several cycles repeats the same write, which is harmless.
  - wmask=0 writes nothing.
- IDLE, csb=0 and we=1 (read): latch addr[9:0]; counter <= 1; go to READ_WAIT; data_ready stays 0.
- READ_WAIT: counter increments each edge. All inputs are ignored except reset; mid-read writes are dropped. On the edge where counter reaches READ_LATENCY:
  - data_out <= mem[latched addr];
  - data_ready <= 1;
  - go to READ_DONE.
  - Net effect: a read accepted at edge k shows data_ready=1 and valid data_out after edge k+6.
- READ_DONE: data_out and data_ready hold while csb=0. At the first edge with csb=1: data_ready <= 0; go to IDLE; data_out holds its last value.
  - A new command issues only after returning to IDLE, so back-to-back reads need one csb=1 cycle between them.
- Read data reflects array contents at the edge data_ready is set. No read-during-write hazard exists, because writes are blocked outside IDLE.
- Reset mid-read (READ_WAIT or READ_DONE): the read is aborted; data_ready=0 and data_out=0 after the reset edge.
- Reading a never-written word returns X in simulation. This is permitted; benches must not depend on it.
- Consumer rule: sample data_out only while data_ready=1.

Test Plan:
- Basic write/read: reset; write addr=48, wmask=0xFF, data_in=77; write addr=49, data_in=1; read addr=48 -> data_ready rises exactly 6 edges after read acceptance, data_out=77. Then read 49 -> data_out=1.
- Byte mask: write addr=50, data=0xFFFFFFFFFFFFFFFF, wmask=0xFF; write addr=50, data=0, wmask=0x0F; read 50 -> data_out=0xFFFFFFFF00000000.
- No-op/deselect: csb=1, we=0, addr=48, data_in=5 for several cycles -> later read of 48 still returns 77; data_ready remains 0 throughout.
- Handshake release: after data_ready=1, keep csb=0 for 3 cycles -> data_ready and data_out stable. Raise csb -> data_ready=0 after next edge. Issue a new read -> it is accepted and completes with 6-edge latency.
- Write blocked during read: issue read of 48; during READ_WAIT drive we=0, data_in=9 to addr 48 -> read returns 77; subsequent read also returns 77.
- Reset mid-read: issue read; assert rst_n at edge 3 -> data_ready=0 and data_out=0; no data_ready pulse follows; a subsequent read works normally.

Source files
------------

// File: rtl/sram_wrap_l1_64x1024.sv
// L1 cache data store: 1024 x 64-bit single-port SRAM wrapper.
// One-cycle byte-masked writes; reads complete after a fixed latency and are
// flagged by data_ready, which holds until the requester releases chip select.
module sram_wrap_l1_64x1024 #(
    parameter int unsigned NUM_WMASKS   = 8,
    parameter int unsigned DATA_WIDTH   = 65,
    parameter int unsigned ADDR_WIDTH   = 11,
    parameter int unsigned READ_LATENCY = 6
) (
    input  logic                    clk,
    input  logic                    rst_n,      // synchronous, active-high
    input  logic                    csb,        // chip select, active low
    input  logic                    we,         // 0 = write, 1 = read
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [DATA_WIDTH-2:0]   data_in,
    input  logic [NUM_WMASKS-1:0]   wmask,
    output logic [DATA_WIDTH-2:0]   data_out,
    output logic                    data_ready
);

    localparam int unsigned DW    = DATA_WIDTH - 1;
    localparam int unsigned IW    = ADDR_WIDTH - 1;
    localparam int unsigned DEPTH = 1 << IW;
    localparam int unsigned CW    = $clog2(READ_LATENCY + 1);

    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(READ_LATENCY);

    typedef enum logic [1:0] {
        StIdle,
        StReadWait,
        StReadDone
    } state_e;

    state_e          r_state, w_state_next;
    logic [CW-1:0]   r_cnt, w_cnt_next;
    logic [IW-1:0]   r_addr, w_addr_next;
    logic [DW-1:0]   r_data_out, w_data_out_next;
    logic            r_ready, w_ready_next;
    logic            w_wr_en;
    logic            w_unused_addr_msb;

    logic [DW-1:0]   r_mem [DEPTH];

    // Top address bit aliases onto the lower half of the address space.
    assign w_unused_addr_msb = addr[ADDR_WIDTH-1];

    // Writes are only accepted from idle, so no read can observe a write in flight.
    assign w_wr_en = !rst_n && (r_state == StIdle) && !csb && !we;

    // Array storage: byte-masked write, contents survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int i = 0; i < int'(NUM_WMASKS); i++) begin
                if (wmask[i]) begin
                    r_mem[addr[IW-1:0]][8*i +: 8] <= data_in[8*i +: 8];
                end
            end
        end
    end

    // Next-state and output logic for the read handshake.
    always_comb begin
        w_state_next    = r_state;
        w_cnt_next      = r_cnt;
        w_addr_next     = r_addr;
        w_data_out_next = r_data_out;
        w_ready_next    = r_ready;
        unique case (r_state)
            StIdle: begin
                if (!csb && we) begin
                    w_addr_next  = addr[IW-1:0];
                    w_cnt_next   = CNT_ONE;
                    w_state_next = StReadWait;
                end
            end
            StReadWait: begin
                // Counter starts at 1 on acceptance, so data lands READ_LATENCY edges later.
                if (r_cnt == CNT_LAST) begin
                    w_data_out_next = r_mem[r_addr];
                    w_ready_next    = 1'b1;
                    w_cnt_next      = '0;
                    w_state_next    = StReadDone;
                end else begin
                    w_cnt_next = r_cnt + CNT_ONE;
                end
            end
            StReadDone: begin
                if (csb) begin
                    w_ready_next = 1'b0;
                    w_state_next = StIdle;
                end
            end
            default: begin
                w_state_next = StIdle;
            end
        endcase
    end

    // State register with synchronous reset taking priority.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_state    <= StIdle;
            r_cnt      <= '0;
            r_addr     <= '0;
            r_data_out <= '0;
            r_ready    <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cnt      <= w_cnt_next;
            r_addr     <= w_addr_next;
            r_data_out <= w_data_out_next;
            r_ready    <= w_ready_next;
        end
    end

    assign data_out   = r_data_out;
    assign data_ready = r_ready;

endmodule

// File: tb/tb_sram_wrap_l1_64x1024.sv
// Self-checking bench for sram_wrap_l1_64x1024: directed scenarios followed by
// randomized masked writes and reads checked against a word-array model.
module tb_sram_wrap_l1_64x1024;

    logic        clk;
    logic        rst_n;
    logic        csb;
    logic        we;
    logic [10:0] addr;
    logic [63:0] data_in;
    logic [7:0]  wmask;
    logic [63:0] data_out;
    logic        data_ready;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: plain word array, written byte-by-byte.
    logic [63:0] m_mem [1024];
    logic [10:0] pool [16];

    sram_wrap_l1_64x1024 #(
        .NUM_WMASKS  (8),
        .DATA_WIDTH  (65),
        .ADDR_WIDTH  (11),
        .READ_LATENCY(6)
    ) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .csb       (csb),
        .we        (we),
        .addr      (addr),
        .data_in   (data_in),
        .wmask     (wmask),
        .data_out  (data_out),
        .data_ready(data_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled there too.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_write(input logic [10:0] a, input logic [63:0] d, input logic [7:0] m);
        csb = 1'b0; we = 1'b0; addr = a; data_in = d; wmask = m;
        tick();
        csb = 1'b1; we = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) m_mem[a[9:0]][8*i +: 8] = d[8*i +: 8];
        end
    endtask

    // Issue a read, measure latency, optionally hold and poke a write that must be dropped.
    task automatic do_read(input logic [10:0] a, input string tag, input int hold, input bit poke);
        logic [63:0] exp;
        int lat;
        exp = m_mem[a[9:0]];
        csb = 1'b0; we = 1'b1; addr = a; data_in = '0; wmask = 8'h00;
        tick();
        if (poke) begin
            we = 1'b0; wmask = 8'hFF; data_in = {$urandom, $urandom};
        end
        lat = 0;
        while (!data_ready && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, " latency"}, 64'(lat), 64'd6);
        check({tag, " data"}, data_out, exp);
        for (int h = 0; h < hold; h++) begin
            tick();
            check({tag, " hold ready"}, 64'(data_ready), 64'd1);
            check({tag, " hold data"}, data_out, exp);
        end
        csb = 1'b1; we = 1'b1;
        tick();
        check({tag, " release ready"}, 64'(data_ready), 64'd0);
        check({tag, " release data"}, data_out, exp);
    endtask

    initial begin
        int bad;
        logic [10:0] a;
        logic [63:0] d;
        logic [7:0]  m;

        rst_n = 1'b1; csb = 1'b1; we = 1'b1; addr = '0; data_in = '0; wmask = '0;
        @(negedge clk);
        tick();
        tick();
        check("reset ready", 64'(data_ready), 64'd0);
        check("reset data", data_out, 64'd0);
        rst_n = 1'b0;

        // Basic write/read.
        do_write(11'd48, 64'd77, 8'hFF);
        do_write(11'd49, 64'd1, 8'hFF);
        do_read(11'd48, "rd48", 0, 1'b0);
        check("rd48 const", data_out, 64'd77);
        do_read(11'd49, "rd49", 0, 1'b0);
        check("rd49 const", data_out, 64'd1);

        // Byte mask.
        do_write(11'd50, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF);
        do_write(11'd50, 64'd0, 8'h0F);
        do_read(11'd50, "mask", 0, 1'b0);
        check("mask const", data_out, 64'hFFFF_FFFF_0000_0000);

        // Deselected cycles must not write or raise data_ready.
        csb = 1'b1; we = 1'b0; addr = 11'd48; data_in = 64'd5; wmask = 8'hFF;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (data_ready) bad++;
        end
        check("noop ready", 64'(bad), 64'd0);
        we = 1'b1;
        do_read(11'd48, "noop rd", 0, 1'b0);
        check("noop const", data_out, 64'd77);

        // Handshake hold and release, then back-to-back read.
        do_read(11'd48, "hold", 3, 1'b0);
        do_read(11'd49, "after hold", 0, 1'b0);

        // Writes during a read are dropped.
        do_read(11'd48, "blocked", 1, 1'b1);
        check("blocked const", data_out, 64'd77);
        do_read(11'd48, "blocked again", 0, 1'b0);
        check("blocked again const", data_out, 64'd77);

        // Reset mid-read.
        csb = 1'b0; we = 1'b1; addr = 11'd49;
        tick();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("midreset ready", 64'(data_ready), 64'd0);
        check("midreset data", data_out, 64'd0);
        rst_n = 1'b0; csb = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (data_ready) bad++;
        end
        check("midreset no pulse", 64'(bad), 64'd0);
        do_read(11'd49, "post reset", 0, 1'b0);

        // Address bit 10 aliases onto the same word.
        do_write(11'h400 | 11'd51, 64'h0123_4567_89AB_CDEF, 8'hFF);
        do_read(11'd51, "alias", 0, 1'b0);
        check("alias const", data_out, 64'h0123_4567_89AB_CDEF);

        // Randomized traffic over a pool of fully initialized words.
        for (int i = 0; i < 16; i++) begin
            pool[i] = 11'($urandom_range(0, 2047));
            do_write(pool[i], {$urandom, $urandom}, 8'hFF);
        end
        for (int i = 0; i < 60; i++) begin
            a = pool[$urandom_range(0, 15)] ^ (11'($urandom_range(0, 1)) << 10);
            if ($urandom_range(0, 1) == 0) begin
                d = {$urandom, $urandom};
                m = 8'($urandom);
                do_write(a, d, m);
            end else begin
                do_read(a, "rand", int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
